// File: rtl/bp_cce_ucode_ctrl.sv
// rtl/bp_cce_ucode_ctrl.sv - CCE microcode RAM port sequencer/arbiter
// Serialises config traffic onto the 1rw instruction RAM, then hands the port to fetch.
module bp_cce_ucode_ctrl #(
  parameter int cce_pc_width_p          = 8,
  parameter int cce_instr_width_p       = 48,
  parameter int num_cce_instr_ram_els_p = 256
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         cfg_v_i,
  input  logic                         cfg_w_i,
  input  logic [cce_pc_width_p-1:0]    cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic [cce_instr_width_p-1:0] cfg_data_o,
  output logic                         cfg_data_v_o,
  input  logic                         cfg_data_yumi_i,
  input  logic                         mode_normal_i,
  input  logic                         fetch_v_i,
  input  logic [cce_pc_width_p-1:0]    fetch_addr_i,
  output logic                         fetch_en_o,
  output logic                         ram_v_o,
  output logic                         ram_w_o,
  output logic [cce_pc_width_p-1:0]    ram_addr_o,
  output logic [cce_instr_width_p-1:0] ram_data_o,
  input  logic [cce_instr_width_p-1:0] ram_data_i,
  output logic [cce_pc_width_p:0]      loaded_count_o,
  output logic                         err_o
);

  localparam logic [cce_pc_width_p:0] els_lp = (cce_pc_width_p+1)'(num_cce_instr_ram_els_p);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_HOLD = 3'd2,
    S_DRAIN   = 3'd3,
    S_RUN     = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [cce_instr_width_p-1:0]   cfg_data_q, cfg_data_d;
  logic                           cfg_data_v_q, cfg_data_v_d;
  logic                           fetch_en_q, fetch_en_d;
  logic [cce_pc_width_p:0]        loaded_count_q, loaded_count_d;
  logic                           err_q, err_d;

  logic cfg_accept;
  logic cfg_in_range;

  assign cfg_in_range = ({1'b0, cfg_addr_i} < els_lp);
  assign cfg_accept   = cfg_v_i & cfg_ready_o;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      cfg_data_q     <= '0;
      cfg_data_v_q   <= 1'b0;
      fetch_en_q     <= 1'b0;
      loaded_count_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cfg_data_q     <= cfg_data_d;
      cfg_data_v_q   <= cfg_data_v_d;
      fetch_en_q     <= fetch_en_d;
      loaded_count_q <= loaded_count_d;
      err_q          <= err_d;
    end
  end

  // Next-state logic; a pending config request takes priority over entering normal mode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_accept && cfg_in_range && !cfg_w_i) begin
          state_d = S_RD_WAIT;
        end else if (!cfg_v_i && mode_normal_i) begin
          state_d = S_DRAIN;
        end
      end
      S_RD_WAIT: state_d = S_RD_HOLD;
      S_RD_HOLD: begin
        if (cfg_data_yumi_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: state_d = S_RUN;
      S_RUN: begin
        if (!mode_normal_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_data_d     = cfg_data_q;
    cfg_data_v_d   = cfg_data_v_q;
    fetch_en_d     = fetch_en_q;
    loaded_count_d = loaded_count_q;
    err_d          = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_accept) begin
          if (!cfg_in_range) begin
            err_d = 1'b1;
          end else if (cfg_w_i && (loaded_count_q != els_lp)) begin
            loaded_count_d = loaded_count_q + 1'b1;
          end
        end
      end
      S_RD_WAIT: begin
        cfg_data_d   = ram_data_i;
        cfg_data_v_d = 1'b1;
      end
      S_RD_HOLD: begin
        if (cfg_data_yumi_i) begin
          cfg_data_v_d = 1'b0;
        end
      end
      S_DRAIN: fetch_en_d = 1'b1;
      S_RUN: begin
        // Config traffic in normal mode is swallowed and flagged
        if (cfg_accept) begin
          err_d = 1'b1;
        end
        if (!mode_normal_i) begin
          fetch_en_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output logic; the RAM port is forced idle while reset is held
  always_comb begin
    cfg_ready_o = 1'b0;
    ram_v_o     = 1'b0;
    ram_w_o     = 1'b0;
    ram_addr_o  = '0;
    ram_data_o  = '0;
    if (!reset_i) begin
      case (state_q)
        S_IDLE: begin
          cfg_ready_o = 1'b1;
          if (cfg_v_i && cfg_in_range) begin
            ram_v_o    = 1'b1;
            ram_w_o    = cfg_w_i;
            ram_addr_o = cfg_addr_i;
            ram_data_o = cfg_w_i ? cfg_data_i : '0;
          end
        end
        S_RUN: begin
          cfg_ready_o = 1'b1;
          if (fetch_v_i) begin
            ram_v_o    = 1'b1;
            ram_addr_o = fetch_addr_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_data_o     = cfg_data_q;
  assign cfg_data_v_o   = cfg_data_v_q;
  assign fetch_en_o     = fetch_en_q;
  assign loaded_count_o = loaded_count_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_bp_cce_ucode_ctrl.sv
// tb/tb_bp_cce_ucode_ctrl.sv - directed self-checking bench for bp_cce_ucode_ctrl
module tb_bp_cce_ucode_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cfg_v_i;
  logic        cfg_w_i;
  logic [7:0]  cfg_addr_i;
  logic [47:0] cfg_data_i;
  logic        cfg_ready_o;
  logic [47:0] cfg_data_o;
  logic        cfg_data_v_o;
  logic        cfg_data_yumi_i;
  logic        mode_normal_i;
  logic        fetch_v_i;
  logic [7:0]  fetch_addr_i;
  logic        fetch_en_o;
  logic        ram_v_o;
  logic        ram_w_o;
  logic [7:0]  ram_addr_o;
  logic [47:0] ram_data_o;
  logic [47:0] ram_data_i;
  logic [8:0]  loaded_count_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  logic [47:0] mem [0:255];

  always #5 clk_i = ~clk_i;

  // Behavioural 1rw RAM with registered read data
  always @(posedge clk_i) begin
    if (ram_v_o) begin
      if (ram_w_o) mem[ram_addr_o] <= ram_data_o;
      else         ram_data_i      <= mem[ram_addr_o];
    end
  end

  bp_cce_ucode_ctrl #(
    .cce_pc_width_p(8),
    .cce_instr_width_p(48),
    .num_cce_instr_ram_els_p(200)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .cfg_data_o(cfg_data_o), .cfg_data_v_o(cfg_data_v_o),
    .cfg_data_yumi_i(cfg_data_yumi_i), .mode_normal_i(mode_normal_i),
    .fetch_v_i(fetch_v_i), .fetch_addr_i(fetch_addr_i), .fetch_en_o(fetch_en_o),
    .ram_v_o(ram_v_o), .ram_w_o(ram_w_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .loaded_count_o(loaded_count_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_idle();
    cfg_v_i = 1'b0; cfg_w_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
  endtask

  initial begin
    reset_i = 1'b1; cfg_data_yumi_i = 1'b0; mode_normal_i = 1'b0;
    fetch_v_i = 1'b0; fetch_addr_i = '0; ram_data_i = '0;
    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'd1; cfg_data_i = 48'h5;
    adv(); adv();
    chk("rst_ram_v", ram_v_o, 0);
    chk("rst_ready", cfg_ready_o, 0);
    chk("rst_data_v", cfg_data_v_o, 0);
    chk("rst_data", cfg_data_o, 0);
    chk("rst_fetch_en", fetch_en_o, 0);
    chk("rst_loaded", loaded_count_o, 0);
    chk("rst_err", err_o, 0);
    reset_i = 1'b0; cfg_idle();
    #1 chk("idle_ready", cfg_ready_o, 1);
    adv();

    for (int i = 0; i < 4; i++) begin
      cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'(i); cfg_data_i = 48'(i + 1) * 48'h11;
      #1;
      chk("wr_ram_w", ram_w_o, 1);
      chk("wr_ram_addr", ram_addr_o, i);
      chk("wr_ram_data", ram_data_o, (i + 1) * 'h11);
      adv();
    end
    cfg_idle();
    #1;
    chk("wr4_loaded", loaded_count_o, 4);
    chk("wr4_err", err_o, 0);
    chk("wr4_ram_v", ram_v_o, 0);

    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'd5; cfg_data_i = 48'hABC;
    adv();
    cfg_w_i = 1'b0; cfg_data_i = '0;
    #1;
    chk("rd_ram_v", ram_v_o, 1);
    chk("rd_ram_w", ram_w_o, 0);
    chk("rd_ram_addr", ram_addr_o, 5);
    adv();
    cfg_idle();
    #1;
    chk("rdwait_ready", cfg_ready_o, 0);
    chk("rdwait_data_v", cfg_data_v_o, 0);
    chk("rdwait_ram_v", ram_v_o, 0);
    adv();
    for (int i = 0; i < 3; i++) begin
      chk("rdhold_data_v", cfg_data_v_o, 1);
      chk("rdhold_data", cfg_data_o, 48'hABC);
      chk("rdhold_ready", cfg_ready_o, 0);
      adv();
    end
    cfg_data_yumi_i = 1'b1;
    #1 chk("yumi_ready", cfg_ready_o, 0);
    adv();
    cfg_data_yumi_i = 1'b0;
    #1;
    chk("post_yumi_ready", cfg_ready_o, 1);
    chk("post_yumi_data_v", cfg_data_v_o, 0);
    chk("post_yumi_data", cfg_data_o, 48'hABC);
    chk("post_rd_loaded", loaded_count_o, 5);

    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'd6; cfg_data_i = 48'h66; mode_normal_i = 1'b1;
    #1;
    chk("mode_wr_ram_w", ram_w_o, 1);
    chk("mode_wr_addr", ram_addr_o, 6);
    adv();
    cfg_idle();
    #1;
    chk("mode_idle_ready", cfg_ready_o, 1);
    chk("mode_idle_ram_v", ram_v_o, 0);
    adv();
    chk("drain_ready", cfg_ready_o, 0);
    chk("drain_fetch_en", fetch_en_o, 0);
    chk("drain_ram_v", ram_v_o, 0);
    adv();
    fetch_v_i = 1'b1; fetch_addr_i = 8'd3;
    #1;
    chk("run_fetch_en", fetch_en_o, 1);
    chk("run_ram_v", ram_v_o, 1);
    chk("run_ram_addr", ram_addr_o, 3);
    chk("run_ram_w", ram_w_o, 0);
    chk("run_ready", cfg_ready_o, 1);
    chk("run_loaded", loaded_count_o, 6);
    adv();

    fetch_v_i = 1'b0;
    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'd7; cfg_data_i = 48'h77;
    #1;
    chk("run_cfg_ram_w", ram_w_o, 0);
    chk("run_cfg_ram_v", ram_v_o, 0);
    adv();
    cfg_idle();
    #1;
    chk("run_cfg_err", err_o, 1);
    chk("run_cfg_loaded", loaded_count_o, 6);
    adv();
    chk("err_sticky", err_o, 1);
    mode_normal_i = 1'b0; fetch_v_i = 1'b1; fetch_addr_i = 8'd2;
    #1 chk("run_exit_ram_v", ram_v_o, 1);
    adv();
    chk("exit_fetch_en", fetch_en_o, 0);
    chk("exit_ram_v", ram_v_o, 0);
    fetch_v_i = 1'b0;
    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'd7; cfg_data_i = 48'h77;
    #1;
    chk("exit_wr_ram_w", ram_w_o, 1);
    chk("exit_wr_addr", ram_addr_o, 7);
    adv();
    cfg_idle();
    #1 chk("exit_wr_loaded", loaded_count_o, 7);

    reset_i = 1'b1;
    adv();
    reset_i = 1'b0;
    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'd250; cfg_data_i = 48'h1;
    #1 chk("oor_ram_v", ram_v_o, 0);
    adv();
    cfg_w_i = 1'b0; cfg_addr_i = 8'd200;
    #1;
    chk("oor_err", err_o, 1);
    chk("oor_loaded", loaded_count_o, 0);
    chk("oor_rd_ram_v", ram_v_o, 0);
    adv();
    cfg_idle();
    #1;
    chk("oor_rd_ready", cfg_ready_o, 1);
    chk("oor_rd_data_v", cfg_data_v_o, 0);

    for (int i = 0; i < 300; i++) begin
      cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = 8'(i % 200); cfg_data_i = 48'(i);
      if (i == 199) begin
        #1 chk("sat_top_ram_v", ram_v_o, 1);
      end
      adv();
      if (i == 149) chk("sat_mid_loaded", loaded_count_o, 150);
    end
    cfg_idle();
    #1 chk("sat_loaded", loaded_count_o, 200);

    cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_addr_i = 8'd5;
    adv();
    cfg_idle();
    #2 reset_i = 1'b1;
    #1;
    chk("arst_ready", cfg_ready_o, 0);
    chk("arst_data_v", cfg_data_v_o, 0);
    chk("arst_data", cfg_data_o, 0);
    chk("arst_loaded", loaded_count_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_ram_v", ram_v_o, 0);
    adv();
    reset_i = 1'b0;
    #1 chk("arst_rel_ready", cfg_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      adv();
      chk("arst_no_data_v", cfg_data_v_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_cce_ucode_ctrl.md
Name: bp_cce_ucode_ctrl

Overview:
Sequencer and arbiter for the CCE microcode instruction RAM, a single-port synchronous 1rw memory with registered read data. It serialises configuration reads and writes onto the RAM port while the CCE is in init/uncached mode. Once normal mode is requested and the last config write has drained, it hands the port to instruction fetch. It tracks how many words have been loaded and flags illegal config traffic.

Parameters:
cce_pc_width_p, 8, RAM address width
cce_instr_width_p, 48, RAM word width
num_cce_instr_ram_els_p, 256, RAM depth; must be <= 2^cce_pc_width_p

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
cfg_v_i  in  1  config request valid
cfg_w_i  in  1  1 = write, 0 = read
cfg_addr_i  in  cce_pc_width_p  config RAM address
cfg_data_i  in  cce_instr_width_p  config write data
cfg_ready_o  out  1  config request accepted when cfg_v_i & cfg_ready_o
cfg_data_o  out  cce_instr_width_p  config read data
cfg_data_v_o  out  1  config read data valid
cfg_data_yumi_i  in  1  consumer takes read data
mode_normal_i  in  1  level: CCE requested to run microcode
fetch_v_i  in  1  fetch wants a RAM read this cycle
fetch_addr_i  in  cce_pc_width_p  fetch address
fetch_en_o  out  1  fetch owns RAM; first fetch allowed
ram_v_o  out  1  RAM enable
ram_w_o  out  1  RAM write enable
ram_addr_o  out  cce_pc_width_p  RAM address
ram_data_o  out  cce_instr_width_p  RAM write data
ram_data_i  in  cce_instr_width_p  RAM read data, valid the cycle after a read
loaded_count_o  out  cce_pc_width_p+1  accepted in-range writes, saturating at num_cce_instr_ram_els_p
err_o  out  1  sticky illegal-access flag

Behaviour:
- Asynchronous active-high reset. Reset values: state = IDLE, cfg_data_o = 0, cfg_data_v_o = 0, fetch_en_o = 0, loaded_count_o = 0, err_o = 0. All ram_* outputs are 0 during reset.
- Reset asserted mid-operation aborts any pending read; the read data is lost. After reset deassertion, the first cycle is IDLE.
- States: IDLE, RD_WAIT, RD_HOLD, DRAIN, RUN.
- IDLE:
  - cfg_ready_o = 1.
  - Write accepted with addr < els: same-cycle ram_v_o = ram_w_o = 1, ram_addr_o = cfg_addr_i, ram_data_o = cfg_data_i. loaded_count increments unless already saturated. Stay in IDLE.
  - Read accepted with addr < els: same-cycle ram_v_o = 1, ram_w_o = 0. Next state RD_WAIT.
  - Any accepted request with addr >= els: not issued to RAM, err_o set, stay in IDLE.
  - cfg_v_i = 0 and mode_normal_i = 1: next state DRAIN. If cfg_v_i = 1 in the same cycle, the config request wins.
- RD_WAIT:
  - cfg_ready_o = 0.
  - cfg_data_o <= ram_data_i, cfg_data_v_o <= 1. Next state RD_HOLD.
- RD_HOLD:
  - cfg_ready_o = 0; cfg_data_v_o held until cfg_data_yumi_i.
  - On yumi: cfg_data_v_o <= 0, next state IDLE.
  - cfg_data_o stays stable until the next read completes.
  - Read-to-read minimum spacing is 3 cycles.
- DRAIN:
  - One cycle; no RAM access; cfg_ready_o = 0. Gives the last write time to complete.
  - Next state RUN; fetch_en_o <= 1.
- RUN:
  - fetch_en_o = 1. RAM port is driven by fetch: ram_v_o = fetch_v_i, ram_w_o = 0, ram_addr_o = fetch_addr_i.
  - cfg_ready_o = 1 so illegal requests drain. Any accepted config request is dropped (no RAM access, no read data) and sets err_o.
  - mode_normal_i = 0: fetch_en_o <= 0, next state IDLE. RAM is not driven by fetch in that following cycle.
- fetch_v_i is ignored outside RUN.
- err_o stays set until reset.
- ram_* outputs are 0 whenever no access is issued.

Test Plan:
- Reset, then 4 writes (addr 0..3, data 'h11..'h44) back-to-back -> ram_w_o high 4 consecutive cycles, loaded_count_o = 4, err_o = 0.
- Write addr 5 = 'hABC; read addr 5; hold yumi low 3 cycles -> cfg_data_v_o rises 2 cycles after accept, cfg_data_o = 'hABC stable, cfg_ready_o = 0 until 1 cycle after yumi.
- Raise mode_normal_i with cfg_v_i = 1 (write) in the same cycle -> write issued first, then DRAIN, then fetch_en_o = 1. Fetch addr 3 -> ram_addr_o = 3, ram_w_o = 0.
- In RUN, issue a config write -> no ram_w_o, err_o = 1 sticky. Drop mode_normal_i -> fetch_en_o = 0 next cycle, cfg write accepted normally afterwards.
- With els = 200, write addr 250 -> no RAM access, err_o = 1, loaded_count_o unchanged. 300 in-range writes -> loaded_count_o saturates at 200.
- Assert reset_i asynchronously during RD_WAIT -> all outputs 0 immediately. After release: IDLE, cfg_data_v_o never asserted for the aborted read.
